// File: rtl/noc_egress_sink.sv
// Egress sink for one router output port: buffers pushed flits, drives next_full
// back-pressure, delivers flits in order over valid/ready, and keeps header/drop stats.
module noc_egress_sink #(
    parameter int          WD       = 40,
    parameter int          DEPTH    = 4,
    parameter int          SKID     = 1,
    parameter logic [3:0]  EXP_HDR  = 4'b0100,
    parameter logic [3:0]  HDR_MASK = 4'b1111
) (
    input  logic          wclk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WD-1:0] wdata,
    output logic          next_full,
    output logic          out_valid,
    output logic [WD-1:0] out_data,
    input  logic          out_ready,
    input  logic          clr_err,
    output logic          hdr_err,
    output logic          overflow,
    output logic [15:0]   rx_count,
    output logic [7:0]    drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C   = (AW+1)'(DEPTH);
    localparam logic [AW:0] FULL_THR  = (AW+1)'(DEPTH - SKID);

    logic [WD-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          out_valid_reg;
    logic [WD-1:0] out_data_reg;
    logic          hdr_err_reg;
    logic          overflow_reg;
    logic [15:0]   rx_count_reg;
    logic [7:0]    drop_count_reg;

    logic       accept;
    logic       drop;
    logic       move;
    logic       consume;
    logic       hdr_bad;
    logic [3:0] hdr_bit_bad;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_hdr
            assign hdr_bit_bad[gi] = HDR_MASK[gi] & (wdata[WD-4+gi] ^ EXP_HDR[gi]);
        end
    endgenerate

    assign hdr_bad = |hdr_bit_bad;
    // Full decision uses the pre-edge count; a simultaneous move never rescues a write.
    assign accept  = wr_en && (count_reg != DEPTH_C);
    assign drop    = wr_en && (count_reg == DEPTH_C);
    assign move    = (count_reg != '0) && (!out_valid_reg || out_ready);
    assign consume = out_valid_reg && out_ready && !move;

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge wclk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            out_valid_reg  <= 1'b0;
            out_data_reg   <= '0;
            hdr_err_reg    <= 1'b0;
            overflow_reg   <= 1'b0;
            rx_count_reg   <= '0;
            drop_count_reg <= '0;
        end else begin
            if (accept) begin
                wr_ptr_reg   <= wr_ptr_reg + 1'b1;
                rx_count_reg <= rx_count_reg + 16'd1;
            end
            if (move) begin
                out_data_reg  <= mem[rd_ptr_reg];
                out_valid_reg <= 1'b1;
                rd_ptr_reg    <= rd_ptr_reg + 1'b1;
            end else if (consume) begin
                out_valid_reg <= 1'b0;
            end
            case ({accept, move})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
            // An error event in the same cycle as a clear takes priority.
            hdr_err_reg  <= (hdr_err_reg && !clr_err) || (accept && hdr_bad);
            overflow_reg <= (overflow_reg && !clr_err) || drop;
            if (clr_err) begin
                drop_count_reg <= drop ? 8'd1 : 8'd0;
            end else if (drop && (drop_count_reg != 8'hFF)) begin
                drop_count_reg <= drop_count_reg + 8'd1;
            end
        end
    end

    assign next_full  = (count_reg >= FULL_THR);
    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign hdr_err    = hdr_err_reg;
    assign overflow   = overflow_reg;
    assign rx_count   = rx_count_reg;
    assign drop_count = drop_count_reg;
endmodule

// File: tb/tb_noc_egress_sink.sv
// Bench for noc_egress_sink: directed vector table, hand-written reset sequences,
// and randomized traffic checked against a queue-based reference model.
module tb_noc_egress_sink;
    localparam int         WD       = 40;
    localparam int         DEPTH    = 4;
    localparam int         SKID     = 1;
    localparam logic [3:0] EXP_HDR  = 4'b0100;
    localparam logic [3:0] HDR_MASK = 4'b1111;

    logic          wclk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [WD-1:0] wdata;
    logic          next_full;
    logic          out_valid;
    logic [WD-1:0] out_data;
    logic          out_ready;
    logic          clr_err;
    logic          hdr_err;
    logic          overflow;
    logic [15:0]   rx_count;
    logic [7:0]    drop_count;

    int n_tests = 0;
    int n_fail  = 0;

    noc_egress_sink #(
        .WD(WD), .DEPTH(DEPTH), .SKID(SKID), .EXP_HDR(EXP_HDR), .HDR_MASK(HDR_MASK)
    ) dut (
        .wclk(wclk), .rst_n(rst_n), .wr_en(wr_en), .wdata(wdata),
        .next_full(next_full), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .clr_err(clr_err), .hdr_err(hdr_err),
        .overflow(overflow), .rx_count(rx_count), .drop_count(drop_count)
    );

    always #5 wclk = ~wclk;

    // Reference model: every flit held by the block, oldest first; the head is
    // on the output when m_shown is set, the rest sit in the array.
    logic [WD-1:0] held[$];
    bit            m_shown;
    logic [15:0]   m_rx;
    logic [7:0]    m_drop;
    bit            m_hdr;
    bit            m_ovf;

    task automatic model_reset();
        held.delete();
        m_shown = 0; m_rx = 0; m_drop = 0; m_hdr = 0; m_ovf = 0;
    endtask

    task automatic model_edge(input bit wr, input logic [WD-1:0] d, input bit rdy, input bit clr);
        int  in_array;
        bit  acc, drp, mv, bad;
        in_array = held.size() - (m_shown ? 1 : 0);
        acc = wr && (in_array < DEPTH);
        drp = wr && !acc;
        mv  = (in_array > 0) && (!m_shown || rdy);
        bad = ((d[WD-1:WD-4] & HDR_MASK) != (EXP_HDR & HDR_MASK));
        if (m_shown && rdy) void'(held.pop_front());
        m_shown = mv || (m_shown && !rdy);
        if (acc) begin
            held.push_back(d);
            m_rx = m_rx + 16'd1;
        end
        m_hdr = (m_hdr && !clr) || (acc && bad);
        m_ovf = (m_ovf && !clr) || drp;
        if (clr) m_drop = drp ? 8'd1 : 8'd0;
        else if (drp && m_drop != 8'hFF) m_drop = m_drop + 8'd1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input bit wr, input logic [WD-1:0] d, input bit rdy, input bit clr);
        wr_en = wr; wdata = d; out_ready = rdy; clr_err = clr;
        @(posedge wclk);
        model_edge(wr, d, rdy, clr);
        #1;
    endtask

    task automatic do_reset(input int edges, input bit wr);
        rst_n = 1'b0; wr_en = wr; wdata = 40'h40_0000_00AA; out_ready = 1'b0; clr_err = 1'b0;
        repeat (edges) @(posedge wclk);
        #1;
        model_reset();
        rst_n = 1'b1; wr_en = 1'b0;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_shown));
        if (m_shown) chk({tag, ".data"}, 64'(out_data), 64'(held[0]));
        chk({tag, ".full"}, 64'(next_full),
            64'((held.size() - (m_shown ? 1 : 0)) >= DEPTH - SKID));
        chk({tag, ".rx"},   64'(rx_count),   64'(m_rx));
        chk({tag, ".drop"}, 64'(drop_count), 64'(m_drop));
        chk({tag, ".hdr"},  64'(hdr_err),    64'(m_hdr));
        chk({tag, ".ovf"},  64'(overflow),   64'(m_ovf));
    endtask

    typedef struct {
        bit            wr;
        logic [WD-1:0] d;
        bit            rdy;
        bit            clr;
        bit            e_valid;
        logic [WD-1:0] e_data;
        bit            e_full;
        logic [15:0]   e_rx;
        logic [7:0]    e_drop;
        bit            e_hdr;
        bit            e_ovf;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit wr, input logic [WD-1:0] d, input bit rdy, input bit clr,
                       input bit ev, input logic [WD-1:0] ed, input bit ef,
                       input int erx, input int edrop, input bit eh, input bit eo);
        vec_t v;
        v.wr = wr; v.d = d; v.rdy = rdy; v.clr = clr;
        v.e_valid = ev; v.e_data = ed; v.e_full = ef;
        v.e_rx = 16'(erx); v.e_drop = 8'(edrop); v.e_hdr = eh; v.e_ovf = eo;
        vq.push_back(v);
    endtask

    initial begin
        logic [WD-1:0] f [7];
        logic [WD-1:0] bad_flit;
        logic [WD-1:0] rd;
        for (int i = 0; i < 7; i++) f[i] = 40'h40_0000_0000 + 40'(i);
        bad_flit = 40'h90_0000_0002;

        // Reset held two edges with a push pending: nothing may be written.
        do_reset(2, 1'b1);
        chk("reset.valid", 64'(out_valid), 64'd0);
        chk("reset.data",  64'(out_data),  64'd0);
        chk("reset.full",  64'(next_full), 64'd0);
        chk("reset.rx",    64'(rx_count),  64'd0);
        chk("reset.drop",  64'(drop_count), 64'd0);
        chk("reset.flags", 64'({hdr_err, overflow}), 64'd0);
        step(0, '0, 1, 0);
        step(0, '0, 1, 0);
        chk("reset.nowrite", 64'(out_valid), 64'd0);

        // Directed table: single flit, fill/overflow, drain, header + clear.
        //  wr  data      rdy clr | valid data      full rx drop hdr ovf
        add(1, f[1],      1, 0,    0, '0,        0,  1,  0,  0, 0);
        add(0, '0,        1, 0,    1, f[1],      0,  1,  0,  0, 0);
        add(0, '0,        1, 0,    0, '0,        0,  1,  0,  0, 0);
        add(1, f[1],      0, 0,    0, '0,        0,  2,  0,  0, 0);
        add(1, f[2],      0, 0,    1, f[1],      0,  3,  0,  0, 0);
        add(1, f[3],      0, 0,    1, f[1],      0,  4,  0,  0, 0);
        add(1, f[4],      0, 0,    1, f[1],      1,  5,  0,  0, 0);
        add(1, f[5],      0, 0,    1, f[1],      1,  6,  0,  0, 0);
        add(1, f[6],      0, 0,    1, f[1],      1,  6,  1,  0, 1);
        add(0, '0,        1, 0,    1, f[2],      1,  6,  1,  0, 1);
        add(0, '0,        1, 0,    1, f[3],      0,  6,  1,  0, 1);
        add(0, '0,        1, 0,    1, f[4],      0,  6,  1,  0, 1);
        add(0, '0,        1, 0,    1, f[5],      0,  6,  1,  0, 1);
        add(0, '0,        1, 0,    0, '0,        0,  6,  1,  0, 1);
        add(1, bad_flit,  1, 0,    0, '0,        0,  7,  1,  1, 1);
        add(0, '0,        1, 0,    1, bad_flit,  0,  7,  1,  1, 1);
        add(0, '0,        1, 1,    0, '0,        0,  7,  0,  0, 0);
        for (int i = 0; i < vq.size(); i++) begin
            step(vq[i].wr, vq[i].d, vq[i].rdy, vq[i].clr);
            chk($sformatf("vec%0d.valid", i), 64'(out_valid), 64'(vq[i].e_valid));
            if (vq[i].e_valid)
                chk($sformatf("vec%0d.data", i), 64'(out_data), 64'(vq[i].e_data));
            chk($sformatf("vec%0d.full", i), 64'(next_full),  64'(vq[i].e_full));
            chk($sformatf("vec%0d.rx", i),   64'(rx_count),   64'(vq[i].e_rx));
            chk($sformatf("vec%0d.drop", i), 64'(drop_count), 64'(vq[i].e_drop));
            chk($sformatf("vec%0d.hdr", i),  64'(hdr_err),    64'(vq[i].e_hdr));
            chk($sformatf("vec%0d.ovf", i),  64'(overflow),   64'(vq[i].e_ovf));
            $display("[TB] vec %0d wr=%0d rdy=%0d clr=%0d -> valid=%0d data=%h full=%0d rx=%0d drop=%0d",
                     i, vq[i].wr, vq[i].rdy, vq[i].clr, out_valid, out_data, next_full,
                     rx_count, drop_count);
        end

        // Error set wins over a simultaneous clear (array is full from here).
        do_reset(1, 1'b0);
        for (int i = 0; i < DEPTH + 1; i++) step(1, f[1], 0, 0);
        step(1, f[2], 0, 1);
        chk("setwins.ovf",  64'(overflow),   64'd1);
        chk("setwins.drop", 64'(drop_count), 64'd1);

        // drop_count saturates at 8'hFF.
        for (int i = 0; i < 300; i++) step(1, f[3], 0, 0);
        chk("sat.drop", 64'(drop_count), 64'hFF);
        chk("sat.rx",   64'(rx_count),   64'(DEPTH + 1));

        // Mid-operation reset with three flits stored: none may reappear.
        do_reset(1, 1'b0);
        for (int i = 0; i < 3; i++) step(1, f[i + 1], 0, 0);
        do_reset(1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(0, '0, 1, 0);
            chk($sformatf("midrst.valid%0d", i), 64'(out_valid), 64'd0);
            chk($sformatf("midrst.full%0d", i),  64'(next_full), 64'd0);
        end
        chk("midrst.rx", 64'(rx_count), 64'd0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            bit wr, rdy, clr;
            wr  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 2) != 0);
            clr = ($urandom_range(0, 40) == 0);
            rd  = {$urandom(), $urandom()};
            if ($urandom_range(0, 4) != 0) rd[WD-1:WD-4] = EXP_HDR;
            if ((i / 200) % 3 == 1) rdy = ($urandom_range(0, 5) == 0);
            step(wr, rd, rdy, clr);
            chk_model($sformatf("rand%0d", i));
            if (i % 250 == 0)
                $display("[TB] rand %0d wr=%0d rdy=%0d clr=%0d -> valid=%0d full=%0d rx=%0d drop=%0d",
                         i, wr, rdy, clr, out_valid, next_full, rx_count, drop_count);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
